restoring_divider_8_by_4: RTL and testbench

Sequential restoring divider, the inverse of the team's 4-bit combinational multiplier. Takes an 8-bit dividend (product width) and a 4-bit divisor. Returns quotient and remainder after one iteration per bit, under a start/busy/done handshake. It sits beside the multiplier under the FSM controller, so stored products can be divided back into their factors.

---
 rtl/restoring_divider_8_by_4.sv | 197 +++++++++++++++++++
 tb/tb_restoring_divider_8_by_4.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_8_by_4.sv
// ---------------------------------------------------------------------------
// restoring_divider_8_by_4
//
// Purpose:
//   Sequential unsigned restoring divider. It divides a DIVIDEND_W-bit
//   dividend by a DIVISOR_W-bit divisor, producing one quotient bit per clock
//   edge, and uses a start/busy/done handshake. It is the inverse of the
//   4-bit combinational multiplier: an 8-bit product divided by one factor
//   gives back the other factor.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   request, sampled only while idle
//   dividend     in   [DIVIDEND_W-1:0] numerator, latched when start is accepted
//   divisor      in   [DIVISOR_W-1:0]  denominator, latched when start is accepted
//   busy         out  high while calculating and during the done cycle
//   done         out  one-cycle pulse; results are valid
//   quotient     out  [DIVIDEND_W-1:0] result, held until the next completion
//   remainder    out  [DIVISOR_W-1:0]  result, held until the next completion
//   div_by_zero  out  set with done when the divisor was 0, held like results
//
// Optional build macro:
//   DIVIDER_SELF_CHECK_EN - compiles a simulation-only checker that verifies
//   quotient*divisor + remainder == dividend and remainder < divisor (or the
//   divide-by-zero result pattern) on every done cycle. Undefined by default;
//   the datapath is identical either way.
// ---------------------------------------------------------------------------
module restoring_divider_8_by_4 #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q,     state_d;
    logic [DIVIDEND_W-1:0] qreg_q,      qreg_d;      // dividend shifting out, quotient shifting in
    logic [DIVISOR_W:0]    prem_q,      prem_d;      // partial remainder, one guard bit
    logic [DIVISOR_W-1:0]  dvsr_q,      dvsr_d;      // latched divisor
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [DIVIDEND_W-1:0] quotient_q,  quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  dz_q,        dz_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;

    // One restoring step: bring down the next dividend bit, then try to
    // subtract. The guard bit lets the trial value reach 2*divisor-1.
    logic [DIVISOR_W:0] trial;
    logic [DIVISOR_W:0] diff;
    logic               qbit;

    assign trial = {prem_q[DIVISOR_W-1:0], qreg_q[DIVIDEND_W-1]};
    assign diff  = trial - {1'b0, dvsr_q};
    assign qbit  = (trial >= {1'b0, dvsr_q});

    always_comb begin
        state_d     = state_q;
        qreg_d      = qreg_q;
        prem_d      = prem_q;
        dvsr_d      = dvsr_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        qreg_d  = dividend;
                        dvsr_d  = divisor;
                        prem_d  = '0;
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end else begin
                        // Divide by zero completes immediately with a fixed pattern.
                        quotient_d  = '1;
                        remainder_d = '0;
                        dz_d        = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end

            ST_CALC: begin
                prem_d = qbit ? diff : trial;
                qreg_d = {qreg_q[DIVIDEND_W-2:0], qbit};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // After the final step the guard bit is always clear,
                    // since the partial remainder is below the divisor.
                    quotient_d  = {qreg_q[DIVIDEND_W-2:0], qbit};
                    remainder_d = prem_d[DIVISOR_W-1:0];
                    dz_d        = 1'b0;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state, so they
        // have no combinational path from start.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            qreg_q      <= '0;
            prem_q      <= '0;
            dvsr_q      <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            qreg_q      <= qreg_d;
            prem_q      <= prem_d;
            dvsr_q      <= dvsr_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dz_q;

`ifdef DIVIDER_SELF_CHECK_EN
    // Shadow copies of the accepted operands; the working dividend register
    // is consumed by the shift, so the checker keeps its own.
    logic [DIVIDEND_W-1:0] chk_dividend_q;
    logic [DIVISOR_W-1:0]  chk_divisor_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_dividend_q <= '0;
            chk_divisor_q  <= '0;
        end else if (state_q == ST_IDLE && start) begin
            chk_dividend_q <= dividend;
            chk_divisor_q  <= divisor;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && done_q) begin
            if (dz_q) begin
                if (quotient_q != {DIVIDEND_W{1'b1}} || remainder_q != '0)
                    $error("divider self-check: %0d/0 gave q=%0d r=%0d",
                           chk_dividend_q, quotient_q, remainder_q);
            end else begin
                if ((int'(quotient_q) * int'(chk_divisor_q) + int'(remainder_q)
                        != int'(chk_dividend_q)) || (remainder_q >= chk_divisor_q))
                    $error("divider self-check: %0d/%0d gave q=%0d r=%0d",
                           chk_dividend_q, chk_divisor_q, quotient_q, remainder_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_restoring_divider_8_by_4.sv
// ---------------------------------------------------------------------------
// tb_restoring_divider_8_by_4
//
// Self-checking bench for restoring_divider_8_by_4: reset values, a table of
// directed divisions, hand-written busy/reset corner sequences, an
// exhaustive sweep of nonzero divisors and a randomized run compared with
// plain '/' and '%' arithmetic.
// ---------------------------------------------------------------------------
module tb_restoring_divider_8_by_4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    restoring_divider_8_by_4 dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Latency is the number of clock edges after the start edge at which done
    // is first seen high: 8 for a division, 0 for divide by zero (done is up
    // in the very cycle following the start edge).
    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one division from an idle, post-edge position and wait for done.
    // Operands are scrambled right after the start edge to show they were latched.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                           output logic [7:0] q, output logic [3:0] r,
                           output logic dz, output int lat, output logic pulse_ok);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
        end
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
        @(posedge clk); #1;
        pulse_ok = !done;
    endtask

    // Reference model: ordinary unsigned integer division.
    task automatic check_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                             input bit verbose);
        logic [7:0] q;
        logic [3:0] r;
        logic       dz, pulse_ok;
        int         lat;
        int         eq, er, elat;
        run_div(a, b, q, r, dz, lat, pulse_ok);
        eq   = (b == 0) ? 255 : int'(a) / int'(b);
        er   = (b == 0) ? 0   : int'(a) % int'(b);
        elat = (b == 0) ? 0   : 8;
        check({tag, " latency"}, lat, elat);
        if (lat >= 0) begin
            check({tag, " quotient"}, int'(q), eq);
            check({tag, " remainder"}, int'(r), er);
            check({tag, " div_by_zero"}, int'(dz), int'(b == 0));
            check({tag, " done_pulse_width"}, int'(pulse_ok), 1);
        end
        if (verbose)
            $display("%s: %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d", tag, a, b, q, r, dz, lat);
    endtask

    initial begin
        logic [7:0] q;
        logic [3:0] r;
        logic       dz, pulse_ok;
        int         lat, ndone;
        logic [7:0] cap_q;
        logic [3:0] cap_r;

        vecs[0] = '{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4, dz: 1'b0, lat: 8};
        vecs[1] = '{a: 8'd255, b: 4'd15, q: 8'd17,  r: 4'd0, dz: 1'b0, lat: 8};
        vecs[2] = '{a: 8'd9,   b: 4'd10, q: 8'd0,   r: 4'd9, dz: 1'b0, lat: 8};
        vecs[3] = '{a: 8'd0,   b: 4'd5,  q: 8'd0,   r: 4'd0, dz: 1'b0, lat: 8};
        vecs[4] = '{a: 8'd100, b: 4'd0,  q: 8'd255, r: 4'd0, dz: 1'b1, lat: 0};
        vecs[5] = '{a: 8'd50,  b: 4'd5,  q: 8'd10,  r: 4'd0, dz: 1'b0, lat: 8};

        // Reset 0 -> 1 -> 0, then idle.
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset quotient", int'(quotient), 0);
        check("reset remainder", int'(remainder), 0);
        check("reset div_by_zero", int'(div_by_zero), 0);
        $display("reset: busy=%0d done=%0d q=%0d r=%0d dz=%0d",
                 busy, done, quotient, remainder, div_by_zero);

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            run_div(vecs[i].a, vecs[i].b, q, r, dz, lat, pulse_ok);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d quotient", i), int'(q), int'(vecs[i].q));
            check($sformatf("vec%0d remainder", i), int'(r), int'(vecs[i].r));
            check($sformatf("vec%0d div_by_zero", i), int'(dz), int'(vecs[i].dz));
            check($sformatf("vec%0d done_pulse_width", i), int'(pulse_ok), 1);
            $display("vec%0d: %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d",
                     i, vecs[i].a, vecs[i].b, q, r, dz, lat);
        end

        // Start while busy is ignored: 200/7 then a 255/1 request three edges later.
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1; dividend = 8'd255; divisor = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; cap_q = '0; cap_r = '0;
        for (int n = 0; n < 20; n++) begin
            if (done) begin
                ndone++;
                cap_q = quotient;
                cap_r = remainder;
            end
            @(posedge clk); #1;
        end
        check("busy_start done_count", ndone, 1);
        check("busy_start quotient", int'(cap_q), 28);
        check("busy_start remainder", int'(cap_r), 4);
        $display("busy_start: 200/7 with ignored 255/1 -> dones=%0d q=%0d r=%0d", ndone, cap_q, cap_r);

        // Reset in the middle of a calculation.
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(done), 0);
        check("midreset quotient", int'(quotient), 0);
        check("midreset remainder", int'(remainder), 0);
        check("midreset div_by_zero", int'(div_by_zero), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midreset no_done", ndone, 0);
        $display("midreset: outputs cleared, dones after reset=%0d", ndone);
        check_div("post_reset", 8'd144, 4'd12, 1'b1);

        // Exhaustive sweep of every dividend against every nonzero divisor.
        for (int b = 1; b < 16; b++) begin
            for (int a = 0; a < 256; a++) begin
                check_div($sformatf("sweep %0d/%0d", a, b), 8'(a), 4'(b), 1'b0);
            end
        end
        $display("sweep: 3840 divisions issued");

        // Randomized operands, including divide by zero.
        for (int i = 0; i < 200; i++) begin
            check_div($sformatf("rand%0d", i), 8'($urandom), 4'($urandom_range(0, 15)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
